// File: rtl/rc5_pkg.sv
// Shared constants and encodings for the RC5-32/12/16 round sequencer.
//   ROUNDS / NPAIRS : round count and number of subkey pairs S[2p], S[2p+1]
//   dp_op_t         : datapath opcode presented on dp_op
//   MODE_ENC/DEC    : value of dp_mode / out_tag for each direction
//   state_t         : controller state encoding
package rc5_pkg;

  localparam int unsigned ROUNDS = 12;
  localparam int unsigned NPAIRS = ROUNDS + 1;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_LOAD   = 2'd1,
    OP_WHITEN = 2'd2,
    OP_ROUND  = 2'd3
  } dp_op_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ENC_WH,
    ST_ENC_RND,
    ST_DEC_RND,
    ST_DEC_WH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   en       : grant enable; no grant is issued while low
//   req[1:0] : request vector
//   gnt[1:0] : one-hot grant (combinational, valid in the requesting cycle)
// The priority register remembers the last granted requester; on a tie the
// other requester wins. It only changes when a grant is actually issued.
module rr_arb2 #(
  parameter logic RST_LAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_q <= RST_LAST;
    else if (|gnt)  last_q <= gnt[1];
  end

endmodule

// File: rtl/rc5_round_ctrl.sv
// Sequencer for one shared iterative RC5 round datapath.
//   clk, clr          : clock, asynchronous active-high reset
//   key_vld           : expanded subkey table valid; falling mid-block aborts
//   enc_vld / enc_rdy : encrypt request / 1-cycle accept pulse (LOAD cycle)
//   dec_vld / dec_rdy : decrypt request / 1-cycle accept pulse (LOAD cycle)
//   dp_op             : datapath opcode (NOP, LOAD, WHITEN, ROUND)
//   dp_mode           : direction of the block in flight (0 enc, 1 dec)
//   dp_pair           : subkey-pair index for WHITEN/ROUND
//   out_vld / out_tag : finished block available / its direction
//   out_rdy           : consumer accepts the finished block
//   abort             : 1-cycle pulse after a block is cancelled
//   busy              : controller is not idle
// All outputs decode from registered state (Moore).
module rc5_round_ctrl
  import rc5_pkg::*;
#(
  parameter int unsigned ROUNDS = rc5_pkg::ROUNDS,
  parameter int unsigned PW     = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          key_vld,
  input  logic          enc_vld,
  output logic          enc_rdy,
  input  logic          dec_vld,
  output logic          dec_rdy,
  output logic [1:0]    dp_op,
  output logic          dp_mode,
  output logic [PW-1:0] dp_pair,
  output logic          out_vld,
  output logic          out_tag,
  input  logic          out_rdy,
  output logic          abort,
  output logic          busy
);

  localparam logic [PW-1:0] CNT_LAST = PW'(ROUNDS);
  localparam logic [PW-1:0] CNT_ONE  = PW'(1);

  state_t        state_q, state_d;
  logic          mode_q;
  logic [PW-1:0] rnd_cnt;
  logic          abort_q, abort_d;
  logic [1:0]    gnt;
  logic          arb_en;

  assign arb_en = (state_q == ST_IDLE) && key_vld;

  rr_arb2 #(
    .RST_LAST (MODE_DEC)
  ) u_arb (
    .clk (clk),
    .rst (clr),
    .en  (arb_en),
    .req ({dec_vld, enc_vld}),
    .gnt (gnt)
  );

  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (|gnt) state_d = ST_LOAD;
      ST_LOAD: begin
        if (!key_vld) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else begin
          state_d = (mode_q == MODE_DEC) ? ST_DEC_RND : ST_ENC_WH;
        end
      end
      ST_ENC_WH: begin
        if (!key_vld) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else begin
          state_d = ST_ENC_RND;
        end
      end
      ST_ENC_RND: begin
        if (!key_vld) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (rnd_cnt == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DEC_RND: begin
        if (!key_vld) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (rnd_cnt == CNT_ONE) begin
          state_d = ST_DEC_WH;
        end
      end
      ST_DEC_WH: begin
        if (!key_vld) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (out_rdy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      abort_q <= 1'b0;
      mode_q  <= MODE_ENC;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      if (|gnt) mode_q <= gnt[1];
    end
  end

  // Counter only moves while staying in a round state, so it stops on the
  // exit bound and can never wrap.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rnd_cnt <= '0;
    end else begin
      unique case (state_q)
        ST_LOAD:    rnd_cnt <= (mode_q == MODE_DEC) ? CNT_LAST : CNT_ONE;
        ST_ENC_RND: if (state_d == ST_ENC_RND) rnd_cnt <= rnd_cnt + CNT_ONE;
        ST_DEC_RND: if (state_d == ST_DEC_RND) rnd_cnt <= rnd_cnt - CNT_ONE;
        default:    rnd_cnt <= rnd_cnt;
      endcase
    end
  end

  always_comb begin
    dp_op   = OP_NOP;
    dp_pair = '0;
    out_vld = 1'b0;
    out_tag = 1'b0;
    enc_rdy = 1'b0;
    dec_rdy = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        dp_op   = OP_LOAD;
        enc_rdy = (mode_q == MODE_ENC);
        dec_rdy = (mode_q == MODE_DEC);
      end
      ST_ENC_WH, ST_DEC_WH: dp_op = OP_WHITEN;
      ST_ENC_RND, ST_DEC_RND: begin
        dp_op   = OP_ROUND;
        dp_pair = rnd_cnt;
      end
      ST_DONE: begin
        out_vld = 1'b1;
        out_tag = mode_q;
      end
      default: ;
    endcase
  end

  assign dp_mode = mode_q;
  assign abort   = abort_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/rc5_round_ctrl.md
Name: rc5_round_ctrl

Overview:
- Sequencing controller for a single shared iterative RC5-32/12/16 round datapath (64-bit block, 128-bit key, 26 subkeys S[0..25] organised as 13 pairs).
- Arbitrates between an encrypt requester and a decrypt requester, then drives the datapath one operation per clock: load, whiten or round, with the subkey-pair index.
- Presents a valid/ready result handshake tagged with the mode that produced it.

Parameters:
- ROUNDS, 12, number of RC5 rounds. The number of subkey pairs, NPAIRS, is ROUNDS+1.
- PW, 4, width of the subkey-pair index. Must satisfy 2^PW > ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- key_vld  in  1  the expanded subkey table is valid.
- enc_vld  in  1  encrypt request pending.
- enc_rdy  out  1  encrypt request accepted (1-cycle pulse).
- dec_vld  in  1  decrypt request pending.
- dec_rdy  out  1  decrypt request accepted (1-cycle pulse).
- dp_op  out  2  datapath opcode: 0 NOP, 1 LOAD, 2 WHITEN, 3 ROUND.
- dp_mode  out  1  0 encrypt, 1 decrypt. Held constant for the whole operation.
- dp_pair  out  PW  subkey-pair index p; the datapath uses S[2p] and S[2p+1].
- out_vld  out  1  the datapath output register holds a finished block.
- out_tag  out  1  mode of the finished block.
- out_rdy  in  1  consumer accepts the result.
- abort  out  1  1-cycle pulse when an operation is cancelled.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (clr=1, asynchronous):
  - state=IDLE, last_grant=decrypt, rnd_cnt=0.
  - All outputs are 0 (dp_op=NOP, dp_pair=0).
- States: IDLE, LOAD, ENC_WH, ENC_RND, DEC_RND, DEC_WH, DONE. Outputs are registered/Moore.
- IDLE:
  - If key_vld=1 and any request is pending, grant and go to LOAD.
  - Only enc_vld pending: grant encrypt. Only dec_vld pending: grant decrypt.
  - Both pending: round-robin; grant the opposite of last_grant, then update last_grant.
  - key_vld=0: no grant and no rdy pulse.
- LOAD (1 cycle):
  - dp_op=LOAD, dp_pair=0, dp_mode=granted mode.
  - The matching *_rdy is high in this cycle only. The requester must hold its data valid through this cycle.
- Encrypt path: LOAD → ENC_WH (WHITEN, pair 0) → ENC_RND for pairs 1..ROUNDS ascending → DONE.
- Decrypt path: LOAD → DEC_RND for pairs ROUNDS..1 descending → DEC_WH (WHITEN, pair 0) → DONE.
- Latency:
  - LOAD in cycle t; datapath ops in t+1..t+ROUNDS+1; DONE and out_vld=1 from t+ROUNDS+2.
  - With defaults this is 14 cycles for both modes.
- DONE:
  - dp_op=NOP, out_vld=1, out_tag=dp_mode.
  - Held until out_rdy=1. That cycle completes the transfer; next state is IDLE and out_vld=0.
  - Back-to-back grants therefore have a minimum 1-cycle IDLE bubble (16-cycle issue interval).
- Counter rnd_cnt (PW bits):
  - Loaded to 1 (enc) or ROUNDS (dec) on LOAD.
  - Increments or decrements by exactly 1 per round cycle; it never wraps.
  - Round-state exit is at rnd_cnt==ROUNDS (enc) or rnd_cnt==1 (dec).
- key_vld falling in LOAD, WH or RND states:
  - Next state is IDLE, abort pulses for 1 cycle, out_vld is never asserted for that block.
  - last_grant keeps the aborted grant.
- key_vld falling in DONE: no effect; the result is already final.
- Request inputs are ignored outside IDLE. The opposite requester may stay asserted and wins the next arbitration.
- clr asserted mid-operation: immediate return to the reset state; no abort pulse.
- enc_rdy and dec_rdy are never high together. out_vld and dp_op≠NOP are never high together.

Decomposition:
- rc5_pkg holds:
  - ROUNDS and NPAIRS constants.
  - The dp_op encodings (OP_NOP, OP_LOAD, OP_WHITEN, OP_ROUND).
  - Mode constants MODE_ENC=0 and MODE_DEC=1.
  - The state encoding.
- Sub-module rr_arb2: 2-requester round-robin arbiter with priority register, a grant-enable input and a one-hot grant output. Kept separate for reuse when more cores share a key table.

Test Plan:
- Reset, then enc_vld=1 with key_vld=1 → enc_rdy pulses in cycle t (dp_op=1); dp_op sequence is 2 (p=0), then 3 with p=1..12; out_vld=1, out_tag=0 at t+14.
- Single decrypt request → dp_op 1, then 3 with p=12..1, then 2 (p=0); out_vld at t+14, out_tag=1. Run with the paired encrypt/decrypt datapaths on key 128'h1: encrypting 64'h0 then decrypting the result returns 64'h0.
- enc_vld=dec_vld=1 held continuously with out_rdy=1 → grants alternate enc, dec, enc, dec; each grant is 16 cycles apart.
- out_rdy=0 for 5 cycles in DONE → out_vld and out_tag are stable; no new rdy pulse until 1 cycle after out_rdy goes high.
- key_vld dropped at round pair 6 → abort pulses once, return to IDLE, no out_vld. With key_vld=0, requests are not granted; once key_vld returns, the next grant goes to the opposite requester.
- clr pulsed mid-round (asynchronously, between edges) → all outputs are 0 immediately; the first post-reset simultaneous request grants encrypt.
